// File: rtl/scan_seq.sv
// ============================================================================
// Module      : scan_seq
// Description : 4-to-16 decoder scan sequencer with per-address dwell,
//               single/continuous sweep modes and a saturating sweep counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_seq #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         A,
  output logic               EN,
  output logic               busy,
  output logic               done,
  output logic [7:0]         sweeps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [3:0]         addr_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;
  logic [7:0]         sweeps_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 4'd0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sweeps_q <= 8'd0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (stop) begin
            state_q <= S_IDLE;
            addr_q  <= 4'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (cnt_q != dwell_q) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (addr_q == 4'd15) begin
              if (sweeps_q != 8'hFF) begin
                sweeps_q <= sweeps_q + 8'd1;
              end
              addr_q <= 4'd0;
              // Single-sweep mode leaves through the one-cycle DONE pulse.
              if (!cont_q) begin
                state_q <= S_DONE;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              addr_q <= addr_q + 4'd1;
            end
          end
        end
        default: begin
          // IDLE and DONE share the start logic; stop blocks a start.
          if (start && !stop) begin
            state_q  <= S_SCAN;
            addr_q   <= 4'd0;
            en_q     <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            sweeps_q <= 8'd0;
            cnt_q    <= '0;
            dwell_q  <= dwell;
            cont_q   <= cont;
          end else begin
            state_q <= S_IDLE;
            addr_q  <= 4'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign A      = addr_q;
  assign EN     = en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sweeps = sweeps_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_seq.sv
// ============================================================================
// Module      : tb_scan_seq
// Description : Self-checking bench for scan_seq against a time-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cont;
  logic [3:0] dwell;
  logic [3:0] A;
  logic       EN;
  logic       busy;
  logic       done;
  logic [7:0] sweeps;

  int n_cmp;
  int n_err;

  // Reference model: phase (0 idle, 1 scanning, 2 done pulse), cycles elapsed
  // since the start edge, latched dwell/mode and completed sweeps.
  int m_phase;
  int m_t;
  int m_d;
  int m_c;
  int m_sweeps;
  int done_seen;

  scan_seq #(.DWELL_W(4)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .cont   (cont),
    .dwell  (dwell),
    .A      (A),
    .EN     (EN),
    .busy   (busy),
    .done   (done),
    .sweeps (sweeps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic p,
                            input logic c, input logic [3:0] d);
    int len;
    if (r) begin
      m_phase  = 0;
      m_sweeps = 0;
      m_d      = 0;
      m_c      = 0;
    end else if (m_phase == 1) begin
      if (p) begin
        m_phase = 0;
      end else begin
        m_t++;
        len = 16 * (m_d + 1);
        m_sweeps = (m_t / len > 255) ? 255 : m_t / len;
        if (m_c == 0 && m_t == len) m_phase = 2;
      end
    end else begin
      if (s && !p) begin
        m_phase  = 1;
        m_t      = 0;
        m_d      = int'(d);
        m_c      = int'(c);
        m_sweeps = 0;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    int ea;
    ea = (m_phase == 1) ? (m_t / (m_d + 1)) % 16 : 0;
    check_val("A",      32'(A),      32'(ea));
    check_val("EN",     32'(EN),     32'(m_phase == 1));
    check_val("busy",   32'(busy),   32'(m_phase == 1));
    check_val("done",   32'(done),   32'(m_phase == 2));
    check_val("sweeps", 32'(sweeps), 32'(m_sweeps));
    if (done) done_seen++;
  endtask

  task automatic step(input logic r, input logic s, input logic p,
                      input logic c, input logic [3:0] d);
    rst   = r;
    start = s;
    stop  = p;
    cont  = c;
    dwell = d;
    @(posedge clk);
    model_edge(r, s, p, c, d);
    #1;
    compare_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    m_phase   = 0;
    m_t       = 0;
    m_d       = 0;
    m_c       = 0;
    m_sweeps  = 0;
    done_seen = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; dwell = 4'd0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);

    // V1: single sweep, dwell 0
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    idle_cycles(20);
    check_val("v1_sweeps", 32'(sweeps), 32'd1);
    check_val("v1_done_count", 32'(done_seen), 32'd1);

    // V2: single sweep, dwell 2 (inputs changed mid-scan must not matter)
    done_seen = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    for (int i = 0; i < 55; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i));
    check_val("v2_done_count", 32'(done_seen), 32'd1);

    // V3: continuous, dwell 0, stop after 40 cycles
    done_seen = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    idle_cycles(40);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_val("v3_sweeps", 32'(sweeps), 32'd2);
    idle_cycles(2);
    check_val("v3_done_count", 32'(done_seen), 32'd0);

    // V4: start+stop in idle ignored; restart attempt mid-scan ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    idle_cycles(30);

    // V5: reset mid-scan while A=7
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    idle_cycles(7);
    check_val("v5_pre_A", 32'(A), 32'd7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    idle_cycles(2);

    // V6: start held across DONE restarts without an IDLE cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    check_val("v6_done", 32'(done), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    check_val("v6_restart_en", 32'(EN), 32'd1);
    check_val("v6_restart_sweeps", 32'(sweeps), 32'd0);
    idle_cycles(40);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'b0 | ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 3)));
    end

    // Sweep counter saturation
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 16 * 258; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("sat_sweeps", 32'(sweeps), 32'd255);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_val("sat_hold", 32'(sweeps), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scan_seq.md
SCAN_SEQ -- requirements
Module: scan_seq

Interface
REQ-001 Parameter: DWELL_W, 4, width of the dwell input and the internal dwell counter.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  level-sampled request to begin a scan; acted on only in IDLE or DONE.
REQ-005 Port: stop  input  1  abort request; acted on in SCAN, and blocks start in IDLE or DONE.
REQ-006 Port: cont  input  1  mode, latched at start: 0 = single sweep, 1 = continuous sweep.
REQ-007 Port: dwell  input  DWELL_W  hold time per address, latched at start; each address is held for dwell+1 cycles.
REQ-008 Port: A  output  4  registered address driven to the 4-to-16 decoder select input.
REQ-009 Port: EN  output  1  registered decoder enable; high only in SCAN.
REQ-010 Port: busy  output  1  registered; high in SCAN.
REQ-011 Port: done  output  1  registered; one-cycle pulse when a single sweep completes.
REQ-012 Port: sweeps  output  8  registered count of completed full sweeps since the last start; saturates at 255.

Function
REQ-013 States SHALL be IDLE, SCAN and DONE, held in a registered state machine.
REQ-014 All outputs SHALL be registered and SHALL be a function of the state and counters only.
REQ-015 IDLE outputs SHALL be: A=0, EN=0, busy=0, done=0; sweeps holds its last value.
REQ-016 In IDLE or DONE, start=1 with stop=0 at edge k SHALL set the following at edge k:
- state=SCAN, A=0, EN=1, busy=1, sweeps=0, dwell counter=0;
- cont and dwell latched from their inputs.
REQ-017 In IDLE or DONE, start=1 with stop=1 SHALL be ignored (stop wins).
REQ-018 In SCAN, the dwell counter SHALL increment each cycle until it equals the latched dwell.
REQ-019 On the cycle after the counter reaches latched dwell, the counter SHALL clear and A SHALL advance by 1.
REQ-020 As a result of REQ-018/019, each A value SHALL be presented with EN=1 for exactly latched_dwell+1 cycles.
REQ-021 When A=15 completes its dwell, sweeps SHALL increment, saturating at 255.
REQ-022 At that same point, with cont=1: A SHALL wrap to 0 and the block SHALL stay in SCAN.
REQ-023 At that same point, with cont=0: state SHALL become DONE with A=0, EN=0, busy=0 and done=1.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE with done=0, unless REQ-016 applies.
REQ-025 A single sweep SHALL hold EN high for exactly 16*(dwell+1) consecutive cycles.
REQ-026 Consecutive A values within a sweep SHALL differ by exactly 1 and SHALL never skip an address.
REQ-027 In SCAN, stop=1 at edge k SHALL at edge k set state=IDLE, A=0, EN=0, busy=0 and done=0; sweeps holds its value.
REQ-028 start in SCAN SHALL be ignored; a change of dwell or cont inputs during SCAN SHALL have no effect.
REQ-029 EN SHALL never be high outside SCAN, and done and busy SHALL never be high in the same cycle.

Reset
REQ-030 rst=1 at a rising edge SHALL force state=IDLE, A=0, EN=0, busy=0, done=0, sweeps=0, dwell counter=0 and latched dwell/cont=0, regardless of state.
REQ-031 rst SHALL take priority over start and stop; reset asserted mid-SCAN SHALL abort with the outputs of REQ-030 on the next edge.

Verification
REQ-032 The bench SHALL cover at least the following directed scenarios:
- V1: rst, then start (dwell=0, cont=0) -> A steps 0..15 one per cycle with EN=1 for 16 cycles; done=1 for one cycle; sweeps=1; then IDLE.
- V2: start with dwell=2, cont=0 -> each A held for 3 cycles; EN high for 48 cycles; done pulses once.
- V3: start with dwell=0, cont=1 for 40 cycles, then stop -> A wraps 15->0 twice; sweeps=2; EN=0 and A=0 the cycle after stop; done never asserted.
- V4: start and stop asserted together in IDLE -> stays IDLE, EN=0; then start alone during SCAN with a new dwell -> no restart, and the original dwell timing is unchanged.
- V5: rst asserted while A=7 in SCAN -> next edge gives A=0, EN=0, busy=0, sweeps=0.
- V6: start held high across the DONE cycle -> a new sweep begins immediately with A=0, EN=1 and no IDLE cycle; sweeps resets to 0.
